// File: rtl/pll_lock_ce_gen.sv
// Lock supervisor for the system PLL: synchronizes the lock flag, holds the core in
// reset until lock has settled, then emits phase-aligned 12/6/3 MHz clock enables.
module pll_lock_ce_gen #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ce_12m,
  output logic       ce_6m,
  output logic       ce_3m,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DIV_LAST    = 4'd11;
  localparam logic [7:0]    LOSS_MAX    = 8'd255;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic          meta_q;
  logic          locked_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [3:0]    div_q, div_d;
  logic          lost_q, lost_d;
  logic [7:0]    loss_q, loss_d;
  logic          ce12_q, ce12_d;
  logic          ce6_q, ce6_d;
  logic          ce3_q, ce3_d;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q     <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      meta_q     <= pll_locked;
      locked_s_q <= meta_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      div_q    <= 4'd0;
      lost_q   <= 1'b0;
      loss_q   <= 8'd0;
      ce12_q   <= 1'b0;
      ce6_q    <= 1'b0;
      ce3_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      lost_q   <= lost_d;
      loss_q   <= loss_d;
      ce12_q   <= ce12_d;
      ce6_q    <= ce6_d;
      ce3_q    <= ce3_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    div_d    = 4'd0;
    lost_d   = lost_q;
    loss_d   = loss_q;
    ce12_d   = 1'b0;
    ce6_d    = 1'b0;
    ce3_d    = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + 8'd1;
          end
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 4'd1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Enables are registered from the next-cycle divider so they line up with div
    if (state_d == RUN) begin
      ce12_d = (div_d == 4'd2) || (div_d == 4'd5) || (div_d == 4'd8) || (div_d == 4'd11);
      ce6_d  = (div_d == 4'd5) || (div_d == 4'd11);
      ce3_d  = (div_d == 4'd11);
    end
  end

  assign core_reset = (state_q != RUN);
  assign ce_12m     = ce12_q;
  assign ce_6m      = ce6_q;
  assign ce_3m      = ce3_q;
  assign lock_lost  = lost_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// Directed bench for pll_lock_ce_gen with SETTLE_CYCLES=16.
module tb_pll_lock_ce_gen;

  logic       clk_sys;
  logic       reset;
  logic       pll_locked;
  logic       core_reset;
  logic       ce_12m;
  logic       ce_6m;
  logic       ce_3m;
  logic       lock_lost;
  logic [7:0] loss_count;

  int vecs;
  int errs;

  pll_lock_ce_gen #(.SETTLE_CYCLES(16)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .ce_12m     (ce_12m),
    .ce_6m      (ce_6m),
    .ce_3m      (ce_3m),
    .lock_lost  (lock_lost),
    .loss_count (loss_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges from the first edge sampling pll_locked=1 until core_reset is low; -1 on timeout
  task automatic wait_release(output int edges);
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (core_reset === 1'b0) begin
        edges = n - 1;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int c12, c6, c3, bad, first3;
    logic prev12;
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    pll_locked = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_ce", 32'({ce_3m, ce_6m, ce_12m}), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_loss_count", 32'(loss_count), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    // Clean lock: release 18 edges after the first sampling edge
    pll_locked = 1'b1;
    step();
    for (int k = 0; k < 17; k++) step();
    chk("clean_pre_release", 32'(core_reset), 32'd1);
    step();
    chk("clean_release", 32'(core_reset), 32'd0);
    chk("clean_div0_ce", 32'({ce_3m, ce_6m, ce_12m}), 32'd0);
    step();
    chk("clean_div1_ce12", 32'(ce_12m), 32'd0);
    step();
    chk("clean_first_ce12", 32'({ce_3m, ce_6m, ce_12m}), 32'b001);

    // Enable pattern over 120 RUN cycles (starting at div=2)
    c12 = 0; c6 = 0; c3 = 0; bad = 0; first3 = -1; prev12 = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (ce_12m) c12++;
      if (ce_6m) c6++;
      if (ce_3m) c3++;
      if (ce_3m && !(ce_6m && ce_12m)) bad++;
      if (ce_6m && !ce_12m) bad++;
      if (ce_12m && prev12) bad++;
      if (core_reset !== 1'b0) bad++;
      if (ce_3m && first3 < 0) first3 = i;
      prev12 = ce_12m;
      step();
    end
    chk("pat_ce12_count", 32'(c12), 32'd40);
    chk("pat_ce6_count", 32'(c6), 32'd20);
    chk("pat_ce3_count", 32'(c3), 32'd10);
    chk("pat_violations", 32'(bad), 32'd0);
    chk("pat_first_ce3_idx", 32'(first3), 32'd9);

    // Drop during RUN for 5 cycles
    pll_locked = 1'b0;
    step();
    chk("drop_run_F", 32'(core_reset), 32'd0);
    step();
    chk("drop_run_F1", 32'(core_reset), 32'd0);
    chk("drop_run_F1_lost", 32'(lock_lost), 32'd0);
    step();
    chk("drop_run_F2_core_reset", 32'(core_reset), 32'd1);
    chk("drop_run_F2_ce", 32'({ce_3m, ce_6m, ce_12m}), 32'd0);
    chk("drop_run_lock_lost", 32'(lock_lost), 32'd1);
    chk("drop_run_loss_count", 32'(loss_count), 32'd1);
    step();
    step();
    pll_locked = 1'b1;
    wait_release(edges);
    chk("drop_run_rerelease", 32'(edges), 32'd18);

    // Reset in RUN with lock held high
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1;
    step();
    chk("rstrun_core_reset", 32'(core_reset), 32'd1);
    chk("rstrun_ce", 32'({ce_3m, ce_6m, ce_12m}), 32'd0);
    chk("rstrun_lock_lost", 32'(lock_lost), 32'd0);
    chk("rstrun_loss_count", 32'(loss_count), 32'd0);
    reset = 1'b0;
    wait_release(edges);
    chk("rstrun_rerelease", 32'(edges), 32'd18);

    // Drop during SETTLE at settle count 8
    reset = 1'b1;
    pll_locked = 1'b0;
    step();
    reset = 1'b0;
    step();
    pll_locked = 1'b1;
    for (int k = 0; k < 11; k++) step();
    chk("drop_settle_in_settle", 32'(core_reset), 32'd1);
    pll_locked = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("drop_settle_core_reset", 32'(core_reset), 32'd1);
    chk("drop_settle_lock_lost", 32'(lock_lost), 32'd0);
    chk("drop_settle_loss_count", 32'(loss_count), 32'd0);
    pll_locked = 1'b1;
    wait_release(edges);
    chk("drop_settle_full_resettle", 32'(edges), 32'd18);
    chk("drop_settle_loss_after", 32'(loss_count), 32'd0);

    // Saturation: 260 lock drops in RUN
    bad = 0;
    for (int d = 0; d < 260; d++) begin
      pll_locked = 1'b0;
      for (int k = 0; k < 4; k++) step();
      if (d == 99) chk("sat_loss_at_100", 32'(loss_count), 32'd100);
      pll_locked = 1'b1;
      wait_release(edges);
      if (edges != 18) bad++;
    end
    chk("sat_release_errors", 32'(bad), 32'd0);
    chk("sat_loss_count", 32'(loss_count), 32'd255);
    chk("sat_lock_lost", 32'(lock_lost), 32'd1);
    chk("sat_core_reset", 32'(core_reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
